// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: data width, ALU opcodes and
// the stack ALU engine state encoding.
package stack_cpu_pkg;

  localparam int DEF_DATA_W = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP_B = 3'd1,
    ST_POP_A = 3'd2,
    ST_EXEC  = 3'd3,
    ST_PUSH  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Opcodes 6..15 are reserved and rejected by the engine.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/stack_alu_datapath.sv
// Combinational ALU for the stack engine: computes A op B with zero and
// signed-overflow flags; the engine registers the outputs.
module stack_alu_datapath
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] value,
  output logic              zero,
  output logic              ovf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              a_lt_b;

  assign sum    = a + b;
  assign diff   = a - b;
  assign a_lt_b = ($signed(a) < $signed(b));

  always_comb begin
    value = '0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        value = sum;
        // Overflow when both operands share a sign the sum does not.
        ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        value = diff;
        ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  value = a & b;
      OP_OR:   value = a | b;
      OP_SLT:  value = {{(DATA_W-1){1'b0}}, a_lt_b};
      OP_NOR:  value = ~(a | b);
      default: value = '0;
    endcase
    zero = (value == '0);
  end

endmodule

// File: rtl/stack_alu_engine.sv
// Stack ALU engine: accepts one command, pops B then A from the stack,
// computes A op B and pushes the result back.
module stack_alu_engine
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] stack_top,
  input  logic [CNT_W-1:0]  stack_count,
  output logic              pop,
  output logic              push,
  output logic [DATA_W-1:0] push_data,
  output logic              done,
  output logic              error,
  output logic              zero,
  output logic              ovf,
  output logic [DATA_W-1:0] result,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d, push_data_q, push_data_d;
  logic              zero_q, zero_d, ovf_q, ovf_d;
  logic              pop_q, pop_d, push_q, push_d, done_q, done_d, error_q, error_d;

  logic [DATA_W-1:0] dp_value;
  logic              dp_zero, dp_ovf;

  stack_alu_datapath #(.DATA_W(DATA_W)) u_datapath (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .value (dp_value),
    .zero  (dp_zero),
    .ovf   (dp_ovf)
  );

  // Command handshake: a command is taken on any rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE, so cmd_valid
  // and cmd_op are ignored for the whole duration of a command.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          state_d = (!op_legal(cmd_op) || (stack_count < CNT_W'(2))) ? ST_ERR : ST_POP_B;
        end
      end
      ST_POP_B: begin
        b_d     = stack_top;
        state_d = ST_POP_A;
      end
      ST_POP_A: begin
        a_d     = stack_top;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = dp_value;
        zero_d   = dp_zero;
        ovf_d    = dp_ovf;
        state_d  = ST_PUSH;
      end
      ST_PUSH: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    pop_d       = (state_d == ST_POP_B) || (state_d == ST_POP_A);
    push_d      = (state_d == ST_PUSH);
    done_d      = (state_d == ST_PUSH) || (state_d == ST_ERR);
    error_d     = (state_d == ST_ERR);
    push_data_d = (state_d == ST_PUSH) ? result_d : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pop_q       <= 1'b0;
      push_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      pop_q       <= pop_d;
      push_q      <= push_d;
      done_q      <= done_d;
      error_q     <= error_d;
      push_data_q <= push_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign pop       = pop_q;
  assign push      = push_q;
  assign push_data = push_data_q;
  assign done      = done_q;
  assign error     = error_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_alu_engine.sv
// Directed bench for stack_alu_engine with a behavioural stack responder.
module tb_stack_alu_engine;
  import stack_cpu_pkg::*;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] stack_top;
  logic [7:0]  stack_count;
  logic        pop;
  logic        push;
  logic [15:0] push_data;
  logic        done;
  logic        error;
  logic        zero;
  logic        ovf;
  logic [15:0] result;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  stack_alu_engine #(.DATA_W(16), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .stack_top   (stack_top),
    .stack_count (stack_count),
    .pop         (pop),
    .push        (push),
    .push_data   (push_data),
    .done        (done),
    .error       (error),
    .zero        (zero),
    .ovf         (ovf),
    .result      (result),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stack responder: entries mem[0..sp-1], top at mem[sp-1]
  logic [15:0] mem [0:7] = '{default: 16'h0};
  int          sp = 0;
  logic        load_en = 1'b0;
  logic [15:0] load_v [0:3];
  int          load_n = 0;
  bit          overlap = 1'b0;

  assign stack_top   = (sp > 0) ? mem[sp-1] : 16'h0;
  assign stack_count = 8'(sp);

  always @(posedge clock) begin
    if (pop && push) overlap <= 1'b1;
    if (load_en) begin
      sp <= load_n;
      for (int i = 0; i < 4; i++) mem[i] <= load_v[i];
    end else if (pop) begin
      sp <= sp - 1;
    end else if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + 1;
    end
  end

  // Driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [15:0] v3);
    load_n    = n;
    load_v[0] = v0;
    load_v[1] = v1;
    load_v[2] = v2;
    load_v[3] = v3;
    load_en   = 1'b1;
    @(posedge clock); #1;
    load_en   = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] exp_res,
                         input logic exp_z, input logic exp_v, input bit keep_valid);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clock); #1;
    if (!keep_valid) begin
      cmd_valid = 1'b0;
      cmd_op    = 4'hF;
    end
    chk({tag, " c1 pop"},   32'(pop), 32'd1);
    chk({tag, " c1 ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " c1 push"},  32'(push), 32'd0);
    @(posedge clock); #1;
    chk({tag, " c2 pop"},   32'(pop), 32'd1);
    chk({tag, " c2 push"},  32'(push), 32'd0);
    @(posedge clock); #1;
    chk({tag, " c3 strobes"}, {29'd0, pop, push, done}, 32'd0);
    @(posedge clock); #1;
    chk({tag, " c4 push"},  32'(push), 32'd1);
    chk({tag, " c4 pop"},   32'(pop), 32'd0);
    chk({tag, " c4 done"},  32'(done), 32'd1);
    chk({tag, " c4 error"}, 32'(error), 32'd0);
    chk({tag, " c4 push_data"}, 32'(push_data), 32'(exp_res));
    chk({tag, " c4 result"}, 32'(result), 32'(exp_res));
    chk({tag, " c4 zero"},  32'(zero), 32'(exp_z));
    chk({tag, " c4 ovf"},   32'(ovf), 32'(exp_v));
    chk({tag, " c4 ready"}, 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    chk({tag, " c5 ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " c5 strobes"}, {29'd0, pop, push, done}, 32'd0);
  endtask

  task automatic run_err(input string tag, input logic [3:0] op, input logic [15:0] exp_res,
                         input logic exp_z, input logic exp_v);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk({tag, " c1 done"},  32'(done), 32'd1);
    chk({tag, " c1 error"}, 32'(error), 32'd1);
    chk({tag, " c1 pop/push"}, {30'd0, pop, push}, 32'd0);
    chk({tag, " c1 ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " c1 result"}, 32'(result), 32'(exp_res));
    chk({tag, " c1 zero"},  32'(zero), 32'(exp_z));
    chk({tag, " c1 ovf"},   32'(ovf), 32'(exp_v));
    @(posedge clock); #1;
    chk({tag, " c2 ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " c2 strobes"}, {28'd0, pop, push, done, error}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst outputs", {26'd0, pop, push, done, error, zero, ovf}, 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst push_data", 32'(push_data), 32'd0);
    chk("rst ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;

    // Reset asserted while in POP_A after the first pop
    load(2, 16'd7, 16'd5, 16'd0, 16'd0);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk("midrst c1 pop", 32'(pop), 32'd1);
    @(posedge clock); #1;
    chk("midrst state", 32'(dbg_state), 32'(ST_POP_A));
    reset = 1'b0;
    #1;
    chk("midrst outputs", {26'd0, pop, push, done, error, zero, ovf}, 32'd0);
    chk("midrst ready", 32'(cmd_ready), 32'd1);
    chk("midrst state idle", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("postrst no strobe", {30'd0, pop, push}, 32'd0);
    end
    chk("postrst stack depth", 32'(sp), 32'd1);

    load(2, 16'd7, 16'd5, 16'd0, 16'd0);
    run_cmd("add 7+5", OP_ADD, 16'h000C, 1'b0, 1'b0, 1'b0);
    chk("add depth", 32'(sp), 32'd1);
    chk("add top", 32'(stack_top), 32'h000C);

    load(2, 16'd3, 16'd9, 16'd0, 16'd0);
    run_cmd("sub 3-9", OP_SUB, 16'hFFFA, 1'b0, 1'b0, 1'b0);

    load(2, 16'h7FFF, 16'h0001, 16'd0, 16'd0);
    run_cmd("add ovf", OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Rejected commands leave result and flags alone
    load(1, 16'd5, 16'd0, 16'd0, 16'd0);
    run_err("err count1", OP_ADD, 16'h8000, 1'b0, 1'b1);
    chk("err count1 depth", 32'(sp), 32'd1);
    load(4, 16'd1, 16'd2, 16'd3, 16'd4);
    run_err("err op A", 4'hA, 16'h8000, 1'b0, 1'b1);
    chk("err op A depth", 32'(sp), 32'd4);

    load(2, 16'hF0F0, 16'hFF00, 16'd0, 16'd0);
    run_cmd("and", OP_AND, 16'hF000, 1'b0, 1'b0, 1'b0);
    load(2, 16'hF0F0, 16'hFF00, 16'd0, 16'd0);
    run_cmd("or", OP_OR, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    load(2, 16'h0000, 16'h0000, 16'd0, 16'd0);
    run_cmd("nor", OP_NOR, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    load(2, 16'd4, 16'd4, 16'd0, 16'd0);
    run_cmd("sub zero", OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b0);
    load(2, 16'hFFFE, 16'h0001, 16'd0, 16'd0);
    run_cmd("slt -2<1", OP_SLT, 16'h0001, 1'b0, 1'b0, 1'b0);
    load(2, 16'h0001, 16'hFFFE, 16'd0, 16'd0);
    run_cmd("slt 1<-2", OP_SLT, 16'h0000, 1'b1, 1'b0, 1'b0);

    // cmd_valid held high: second accept only once ready returns
    load(3, 16'd1, 16'd2, 16'd3, 16'd0);
    run_cmd("b2b first", OP_ADD, 16'h0005, 1'b0, 1'b0, 1'b1);
    run_cmd("b2b second", OP_ADD, 16'h0006, 1'b0, 1'b0, 1'b0);
    chk("b2b depth", 32'(sp), 32'd1);
    chk("b2b top", 32'(stack_top), 32'h0006);
    chk("pop/push overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
